// File: rtl/soc_event_dc_rx_if.sv
// soc_event_dc_rx_if: token, data-lane and event-stream bundle of the cluster-side event ring reader
interface soc_event_dc_rx_if #(
  parameter int BUFFER_WIDTH = 8,
  parameter int EVNT_WIDTH = 8
);
  logic [BUFFER_WIDTH-1:0] events_wt_i;
  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_i;
  logic [BUFFER_WIDTH-1:0] events_rp_o;
  logic flush_i;
  logic evt_valid_o;
  logic evt_ready_i;
  logic [EVNT_WIDTH-1:0] evt_data_o;
  logic [$clog2(BUFFER_WIDTH+2)-1:0] pending_o;
  modport master (
    output events_wt_i, events_da_i, flush_i, evt_ready_i,
    input events_rp_o, evt_valid_o, evt_data_o, pending_o
  );
  modport slave (
    input events_wt_i, events_da_i, flush_i, evt_ready_i,
    output events_rp_o, evt_valid_o, evt_data_o, pending_o
  );
endinterface

// File: rtl/soc_event_dc_rx.sv
// soc_event_dc_rx: cluster-side read half of the SoC-to-cluster dual-clock event ring
module soc_event_dc_rx #(
  parameter int BUFFER_WIDTH = 8,
  parameter int EVNT_WIDTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic clk_i,
  input logic rst_ni,
  soc_event_dc_rx_if.slave bus
);
  localparam int IW = $clog2(BUFFER_WIDTH);
  localparam int PW = $clog2(BUFFER_WIDTH + 2);
  logic [SYNC_STAGES-1:0][BUFFER_WIDTH-1:0] sync_q;
  logic [BUFFER_WIDTH-1:0] wt_s, full, rp_q, sel;
  logic [IW-1:0] rd_idx, rd_inc, rd_fl;
  logic [PW-1:0] cnt;
  logic [EVNT_WIDTH-1:0] data_q;
  logic valid_q, load;
  int sum;
  assign wt_s = sync_q[SYNC_STAGES-1];
  assign full = wt_s ^ rp_q;
  assign bus.evt_valid_o = valid_q;
  assign bus.evt_data_o = data_q;
  assign bus.events_rp_o = rp_q;
  assign bus.pending_o = cnt + PW'(valid_q);
  // per-bit token synchronizers; data lanes are held stable by the writer and never synchronized
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], bus.events_wt_i};
  end
  // occupancy, load decision and next read index for normal advance and flush skip
  always_comb begin
    cnt = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) cnt = cnt + PW'(full[i]);
    sum = int'(rd_idx) + int'(cnt);
    load = full[rd_idx] & (~valid_q | bus.evt_ready_i) & ~bus.flush_i;
    rd_inc = (int'(rd_idx) == BUFFER_WIDTH - 1) ? '0 : rd_idx + IW'(1);
    rd_fl = IW'(sum >= BUFFER_WIDTH ? sum - BUFFER_WIDTH : sum);
    sel = BUFFER_WIDTH'(1) << rd_idx;
  end
  // output register and read pointers; flush beats load, load beats a bare pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rp_q <= '0;
      rd_idx <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else if (bus.flush_i) begin
      valid_q <= 1'b0;
      rp_q <= rp_q ^ full;
      rd_idx <= rd_fl;
    end else if (load) begin
      data_q <= bus.events_da_i[int'(rd_idx)*EVNT_WIDTH +: EVNT_WIDTH];
      valid_q <= 1'b1;
      rp_q <= rp_q ^ sel;
      rd_idx <= rd_inc;
    end else if (bus.evt_ready_i & valid_q) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_soc_event_dc_rx.sv
// tb_soc_event_dc_rx: queue-based reference model with per-cycle compare plus directed literal checks
module tb_soc_event_dc_rx;
  localparam int BW = 8, EW = 8, SS = 2, B5 = 5;
  typedef struct { logic [EW-1:0] d; int vis; } ev_t;
  logic clk = 0, rst_n = 0;
  ev_t q[$];
  int ecnt = 0, n_cmp = 0, n_bad = 0, wr = 0, m_rd = 0, m_pend = 0, nv = 0;
  logic m_valid = 0, chk_on = 0;
  logic [EW-1:0] m_data = 0;
  logic [BW-1:0] m_rp = 0;
  always #5 clk = ~clk;
  soc_event_dc_rx_if #(.BUFFER_WIDTH(BW), .EVNT_WIDTH(EW)) b8 ();
  soc_event_dc_rx_if #(.BUFFER_WIDTH(B5), .EVNT_WIDTH(EW)) b5 ();
  soc_event_dc_rx #(.BUFFER_WIDTH(BW), .EVNT_WIDTH(EW), .SYNC_STAGES(SS)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(b8));
  soc_event_dc_rx #(.BUFFER_WIDTH(B5), .EVNT_WIDTH(EW), .SYNC_STAGES(SS)) dut5 (.clk_i(clk), .rst_ni(rst_n), .bus(b5));
  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction
  function automatic int vis_cnt(int t);
    int n = 0;
    foreach (q[k]) if (q[k].vis <= t) n++;
    return n;
  endfunction
  always @(posedge clk) ecnt <= ecnt + 1;
  // reference: pending events are a queue; an event becomes usable SS edges after its token toggles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_rp = 0; m_rd = 0; m_pend = 0;
      q.delete();
    end else begin
      nv = vis_cnt(ecnt);
      if (b8.flush_i) begin
        repeat (nv) begin
          m_rp[m_rd] = ~m_rp[m_rd];
          m_rd = (m_rd + 1) % BW;
          q.delete(0);
        end
        m_valid = 0;
      end else if (nv > 0 && (!m_valid || b8.evt_ready_i)) begin
        m_data = q[0].d;
        q.delete(0);
        m_valid = 1;
        m_rp[m_rd] = ~m_rp[m_rd];
        m_rd = (m_rd + 1) % BW;
      end else if (b8.evt_ready_i) m_valid = 0;
      m_pend = vis_cnt(ecnt + 1) + int'(m_valid);
    end
  end
  // compare every cycle away from the active edge
  always @(negedge clk) if (chk_on) begin
    chk("valid", b8.evt_valid_o, m_valid);
    chk("data", b8.evt_data_o, m_data);
    chk("rp", b8.events_rp_o, m_rp);
    chk("pending", b8.pending_o, m_pend);
  end
  task automatic wr_ev(input logic [EW-1:0] d);
    ev_t e;
    b8.events_da_i[wr*EW +: EW] = d;
    b8.events_wt_i[wr] = ~b8.events_wt_i[wr];
    e.d = d;
    e.vis = ecnt + SS;
    q.push_back(e);
    wr = (wr + 1) % BW;
  endtask
  task automatic wait_valid(input string nm);
    int t = 0;
    while (!b8.evt_valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(nm, b8.evt_valid_o, 1);
  endtask
  initial begin
    int sent, got, t;
    b8.events_wt_i = 0; b8.events_da_i = 0; b8.flush_i = 0; b8.evt_ready_i = 0;
    b5.events_wt_i = 0; b5.events_da_i = 0; b5.flush_i = 0; b5.evt_ready_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_valid", b8.evt_valid_o, 0);
    chk("rst_rp", b8.events_rp_o, 0);
    chk("rst_pending", b8.pending_o, 0);
    rst_n = 1;
    chk_on = 1;
    b8.evt_ready_i = 1;
    wr_ev(8'h5A);
    repeat (2) @(negedge clk);
    chk("t1_not_yet", b8.evt_valid_o, 0);
    chk("t1_pend_visible", b8.pending_o, 1);
    @(negedge clk);
    chk("t1_valid", b8.evt_valid_o, 1);
    chk("t1_data", b8.evt_data_o, 8'h5A);
    chk("t1_rp0", b8.events_rp_o, 8'h01);
    @(negedge clk);
    chk("t1_drop", b8.evt_valid_o, 0);
    b8.evt_ready_i = 0;
    for (int i = 0; i < 8; i++) begin
      wr_ev(EW'(i));
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("t2_pending8", b8.pending_o, 8);
    chk("t2_held", b8.evt_data_o, 0);
    b8.evt_ready_i = 1;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("t2_seq", b8.evt_data_o, k);
      chk("t2_count", b8.pending_o, 8 - k);
    end
    @(negedge clk);
    chk("t2_empty", b8.pending_o, 0);
    for (int c = 0; c < 400; c++) begin
      b8.evt_ready_i = ($urandom_range(0, 3) != 0);
      b8.flush_i = ($urandom_range(0, 49) == 0);
      if (q.size() < BW && $urandom_range(0, 1) == 1) wr_ev(EW'($urandom));
      @(negedge clk);
    end
    b8.flush_i = 0;
    b8.evt_ready_i = 1;
    repeat (10) @(negedge clk);
    b8.evt_ready_i = 0;
    for (int i = 0; i < 4; i++) wr_ev(EW'(8'hA0 + i));
    repeat (4) @(negedge clk);
    chk("t4_pre_pend", b8.pending_o, 4);
    chk("t4_pre_data", b8.evt_data_o, 8'hA0);
    b8.flush_i = 1;
    @(negedge clk);
    b8.flush_i = 0;
    chk("t4_valid", b8.evt_valid_o, 0);
    chk("t4_pend", b8.pending_o, 0);
    b8.evt_ready_i = 1;
    wr_ev(8'hB7);
    wait_valid("t4_after_valid");
    chk("t4_after_data", b8.evt_data_o, 8'hB7);
    b8.evt_ready_i = 0;
    wr_ev(8'h11);
    wait_valid("t5_pre_valid");
    #1;
    rst_n = 0;
    b8.events_wt_i = 0;
    wr = 0;
    #1;
    chk("t5_valid", b8.evt_valid_o, 0);
    chk("t5_rp", b8.events_rp_o, 0);
    chk("t5_data", b8.evt_data_o, 0);
    chk("t5_pend", b8.pending_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    b8.evt_ready_i = 1;
    wr_ev(8'hC3);
    repeat (3) @(negedge clk);
    chk("t5_new_valid", b8.evt_valid_o, 1);
    chk("t5_new_data", b8.evt_data_o, 8'hC3);
    chk("t5_new_rp", b8.events_rp_o, 8'h01);
    sent = 0; got = 0; t = 0;
    b5.evt_ready_i = 1;
    while (got < 12 && t < 300) begin
      if (b5.evt_valid_o) begin
        chk("w5_data", b5.evt_data_o, 8'h40 + got);
        got++;
      end
      if (sent < 12 && sent - got < B5) begin
        b5.events_da_i[(sent % B5)*EW +: EW] = EW'(8'h40 + sent);
        b5.events_wt_i[sent % B5] = ~b5.events_wt_i[sent % B5];
        sent++;
      end
      @(negedge clk);
      t++;
    end
    chk("w5_count", got, 12);
    chk("w5_rp", b5.events_rp_o, 5'b00011);
    chk("w5_pend", b5.pending_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
